// File: rtl/lsu_fault_report.sv
// LSU fault reporter: carries dc1 access/misaligned faults down to dc3 and holds
// one pending mcause/mtval report for decode, counting faults dropped meanwhile.
module lsu_fault_report #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lsu_pkt_valid_dc1,
  input  logic             lsu_pkt_dma_dc1,
  input  logic             lsu_pkt_store_dc1,
  input  logic [31:0]      start_addr_dc1,
  input  logic             access_fault_dc1,
  input  logic             misaligned_fault_dc1,
  input  logic             lsu_freeze_dc3,
  input  logic             dec_tlu_flush_lower,
  input  logic             dec_exc_ack,
  output logic             lsu_exc_valid,
  output logic [3:0]       lsu_exc_cause,
  output logic [31:0]      lsu_exc_addr,
  output logic [CNT_W-1:0] lsu_exc_drop_cnt
);

  typedef enum logic {IDLE, PEND} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // dc1: fault qualification and cause encoding (access outranks misaligned)
  logic        vld_p0;
  logic [3:0]  cause_p0;
  assign vld_p0   = lsu_pkt_valid_dc1 & ~lsu_pkt_dma_dc1 &
                    (access_fault_dc1 | misaligned_fault_dc1);
  assign cause_p0 = {2'b01, lsu_pkt_store_dc1, access_fault_dc1};

  // dc2 (_p1) and dc3 (_p2)
  logic        vld_p1, vld_p2;
  logic [3:0]  cause_p1, cause_p2;
  logic [31:0] addr_p1, addr_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      cause_p1 <= '0;
      cause_p2 <= '0;
      addr_p1  <= '0;
      addr_p2  <= '0;
    end else begin
      if (!lsu_freeze_dc3) begin
        vld_p1   <= vld_p0;
        cause_p1 <= cause_p0;
        addr_p1  <= start_addr_dc1;
        vld_p2   <= vld_p1;
        cause_p2 <= cause_p1;
        addr_p2  <= addr_p1;
      end
      if (dec_tlu_flush_lower) begin
        vld_p1 <= 1'b0;
        vld_p2 <= 1'b0;
      end
    end
  end

  // report FSM: a frozen dc3 entry is only taken on the cycle the freeze lifts
  logic take_p2;
  assign take_p2 = vld_p2 & ~lsu_freeze_dc3;

  state_t     state, state_nxt;
  logic       load, drop;
  logic [3:0] cause_q;
  logic [31:0] addr_q;
  logic [CNT_W-1:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    drop      = 1'b0;
    case (state)
      IDLE: begin
        if (!dec_tlu_flush_lower && take_p2) begin
          load      = 1'b1;
          state_nxt = PEND;
        end
      end
      PEND: begin
        if (dec_tlu_flush_lower) begin
          state_nxt = IDLE;
        end else if (dec_exc_ack) begin
          if (take_p2) load = 1'b1;
          else         state_nxt = IDLE;
        end else if (take_p2) begin
          drop = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cause_q    <= '0;
      addr_q     <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (load) begin
        cause_q <= cause_p2;
        addr_q  <= addr_p2;
      end
      if (drop) drop_cnt_q <= sat_inc(drop_cnt_q);
    end
  end

  always_comb begin
    lsu_exc_valid    = (state == PEND);
    lsu_exc_cause    = lsu_exc_valid ? cause_q : 4'd0;
    lsu_exc_addr     = lsu_exc_valid ? addr_q : 32'd0;
    lsu_exc_drop_cnt = drop_cnt_q;
  end

endmodule

// File: tb/tb_lsu_fault_report.sv
// Bench for lsu_fault_report: directed scenarios plus random traffic, with a
// per-cycle expected-output scoreboard fed from a behavioural model.
module tb_lsu_fault_report;

  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic lsu_pkt_valid_dc1 = 1'b0, lsu_pkt_dma_dc1 = 1'b0, lsu_pkt_store_dc1 = 1'b0;
  logic [31:0] start_addr_dc1 = '0;
  logic access_fault_dc1 = 1'b0, misaligned_fault_dc1 = 1'b0;
  logic lsu_freeze_dc3 = 1'b0, dec_tlu_flush_lower = 1'b0, dec_exc_ack = 1'b0;
  logic lsu_exc_valid;
  logic [3:0] lsu_exc_cause;
  logic [31:0] lsu_exc_addr;
  logic [CNT_W-1:0] lsu_exc_drop_cnt;

  lsu_fault_report #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .lsu_pkt_valid_dc1(lsu_pkt_valid_dc1), .lsu_pkt_dma_dc1(lsu_pkt_dma_dc1),
    .lsu_pkt_store_dc1(lsu_pkt_store_dc1), .start_addr_dc1(start_addr_dc1),
    .access_fault_dc1(access_fault_dc1), .misaligned_fault_dc1(misaligned_fault_dc1),
    .lsu_freeze_dc3(lsu_freeze_dc3), .dec_tlu_flush_lower(dec_tlu_flush_lower),
    .dec_exc_ack(dec_exc_ack), .lsu_exc_valid(lsu_exc_valid),
    .lsu_exc_cause(lsu_exc_cause), .lsu_exc_addr(lsu_exc_addr),
    .lsu_exc_drop_cnt(lsu_exc_drop_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic        valid;
    logic [3:0]  cause;
    logic [31:0] addr;
    int          cnt;
  } exp_t;

  typedef struct {
    bit          fault;
    logic [3:0]  cause;
    logic [31:0] addr;
  } op_t;

  exp_t exp_q[$];

  // model: ops in flight (index 0 = dc2, 1 = dc3), pending report, drop count
  op_t  m_pipe[2];
  bit   m_pend;
  op_t  m_rep;
  int   m_cnt;

  function automatic logic [3:0] mcause(input logic store, input logic acc);
    if (acc) return store ? 4'd7 : 4'd5;
    return store ? 4'd6 : 4'd4;
  endfunction

  task automatic model_step();
    op_t nw, d3;
    bit  take;
    if (rst) begin
      m_pipe[0] = '{0, 0, 0};
      m_pipe[1] = '{0, 0, 0};
      m_pend = 0;
      m_rep = '{0, 0, 0};
      m_cnt = 0;
      return;
    end
    nw.fault = lsu_pkt_valid_dc1 && !lsu_pkt_dma_dc1 && (access_fault_dc1 || misaligned_fault_dc1);
    nw.cause = mcause(lsu_pkt_store_dc1, access_fault_dc1);
    nw.addr  = start_addr_dc1;
    d3   = m_pipe[1];
    take = d3.fault && !lsu_freeze_dc3;
    if (dec_tlu_flush_lower) m_pend = 0;
    else if (!m_pend) begin
      if (take) begin m_pend = 1; m_rep = d3; end
    end else if (dec_exc_ack) begin
      if (take) m_rep = d3;
      else m_pend = 0;
    end else if (take) begin
      m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
    end
    if (!lsu_freeze_dc3) begin
      m_pipe[1] = m_pipe[0];
      m_pipe[0] = nw;
    end
    if (dec_tlu_flush_lower) begin
      m_pipe[0].fault = 0;
      m_pipe[1].fault = 0;
    end
  endtask

  logic n_v = 0, n_dma = 0, n_st = 0, n_ac = 0, n_mi = 0;
  logic [31:0] n_a = '0;

  task automatic set_op(input logic st, input logic [31:0] a, input logic ac,
                        input logic mi, input logic dma = 1'b0);
    n_v = 1; n_st = st; n_a = a; n_ac = ac; n_mi = mi; n_dma = dma;
  endtask

  task automatic step(input logic r = 0, input logic fr = 0, input logic fl = 0,
                      input logic ak = 0);
    exp_t e;
    @(negedge clk);
    rst = r;
    lsu_pkt_valid_dc1 = n_v; lsu_pkt_dma_dc1 = n_dma; lsu_pkt_store_dc1 = n_st;
    start_addr_dc1 = n_a; access_fault_dc1 = n_ac; misaligned_fault_dc1 = n_mi;
    lsu_freeze_dc3 = fr; dec_tlu_flush_lower = fl; dec_exc_ack = ak;
    model_step();
    e.valid = m_pend;
    e.cause = m_pend ? m_rep.cause : 4'd0;
    e.addr  = m_pend ? m_rep.addr : 32'd0;
    e.cnt   = m_cnt;
    exp_q.push_back(e);
    n_v = 0; n_dma = 0; n_st = 0; n_a = '0; n_ac = 0; n_mi = 0;
  endtask

  // directed check of the outputs produced by the step just issued
  task automatic chk(input string nm, input logic v, input logic [3:0] c,
                     input logic [31:0] a, input int cnt);
    @(posedge clk);
    #2;
    total++;
    if (lsu_exc_valid !== v || lsu_exc_cause !== c || lsu_exc_addr !== a ||
        int'(lsu_exc_drop_cnt) != cnt) begin
      bad++;
      $display("FAIL %s: got v=%0b c=%0d a=%h cnt=%0d, want v=%0b c=%0d a=%h cnt=%0d",
               nm, lsu_exc_valid, lsu_exc_cause, lsu_exc_addr, lsu_exc_drop_cnt,
               v, c, a, cnt);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (lsu_exc_valid !== e.valid || lsu_exc_cause !== e.cause ||
          lsu_exc_addr !== e.addr || int'(lsu_exc_drop_cnt) != e.cnt) begin
        bad++;
        $display("FAIL scoreboard @%0t: got v=%0b c=%0d a=%h cnt=%0d, want v=%0b c=%0d a=%h cnt=%0d",
                 $time, lsu_exc_valid, lsu_exc_cause, lsu_exc_addr, lsu_exc_drop_cnt,
                 e.valid, e.cause, e.addr, e.cnt);
      end
    end
  end

  initial begin
    step(1);
    chk("reset", 0, 0, 0, 0);

    // store misaligned: report three cycles after dc1, ack clears it
    set_op(1, 32'h1000_0002, 0, 1);
    step(); step();
    chk("st_mis_early", 0, 0, 0, 0);
    step();
    chk("st_mis_report", 1, 4'd6, 32'h1000_0002, 0);
    step(0, 0, 0, 1);
    chk("st_mis_ack", 0, 0, 0, 0);

    // load with both faults reports access; DMA never reports
    set_op(0, 32'h0000_0040, 1, 1);
    step(); step(); step();
    chk("ld_acc_prio", 1, 4'd5, 32'h0000_0040, 0);
    step(0, 0, 0, 1);
    set_op(0, 32'h0000_0080, 1, 0, 1);
    step(); step(); step();
    chk("dma_ignored", 0, 0, 0, 0);

    // fault in dc2 killed by flush
    set_op(1, 32'h2000_0000, 1, 0);
    step(); step(0, 0, 1); step(); step();
    chk("flush_dc2", 0, 0, 0, 0);

    // flush while pending keeps drop count
    set_op(0, 32'h3000_0000, 1, 0); step();
    set_op(0, 32'h3000_0004, 1, 0); step();
    step(); step();
    chk("pend_one_drop", 1, 4'd5, 32'h3000_0000, 1);
    step(0, 0, 1);
    chk("flush_pend", 0, 0, 0, 1);

    // drop count saturates, ack with simultaneous dc3 fault reloads
    step(1);
    set_op(0, 32'h4000_0000, 0, 1);
    step(); step(); step();
    for (int i = 0; i < 300; i++) begin
      set_op(i[0], 32'h5000_0000 + i, 1, 0);
      step();
    end
    step(); step();
    chk("drop_sat", 1, 4'd4, 32'h4000_0000, 255);
    set_op(1, 32'h6000_0010, 1, 0);
    step(); step(); step(0, 0, 0, 1);
    chk("ack_reload", 1, 4'd7, 32'h6000_0010, 255);

    // frozen dc3 fault reported once, 3+5 cycles after dc1
    step(1);
    set_op(0, 32'h7000_0001, 0, 1);
    step(); step();
    for (int i = 0; i < 4; i++) step(0, 1);
    step(0, 1);
    chk("freeze_wait", 0, 0, 0, 0);
    step();
    chk("freeze_report", 1, 4'd4, 32'h7000_0001, 0);
    step(0, 0, 0, 1);
    chk("freeze_ack", 0, 0, 0, 0);
    step(); step();
    chk("freeze_once", 0, 0, 0, 0);

    // reset in PEND with drop count 3
    set_op(1, 32'h8000_0000, 1, 0); step(); step(); step();
    for (int i = 0; i < 3; i++) begin
      set_op(0, 32'h8000_0100 + i, 0, 1);
      step();
    end
    step(); step();
    chk("pend_cnt3", 1, 4'd7, 32'h8000_0000, 3);
    step(1);
    chk("rst_pend", 0, 0, 0, 0);

    // random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      logic r, fr, fl, ak;
      if ($urandom_range(1, 0) == 1)
        set_op($urandom_range(1, 0), $urandom, $urandom_range(2, 0) == 0,
               $urandom_range(2, 0) == 0, $urandom_range(4, 0) == 0);
      r  = ($urandom_range(299, 0) == 0);
      fr = ($urandom_range(5, 0) == 0);
      fl = ($urandom_range(24, 0) == 0);
      ak = ($urandom_range(3, 0) == 0);
      step(r, fr, fl, ak);
    end

    step();
    repeat (3) @(posedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
